// File: rtl/btn_event_ctrl.sv
// Multi-button front end: per-button sync, debounce and press/long/repeat
// classification on a shared tick, drained through a round-robin valid/ready event slot.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200,
  parameter int CNT_W        = 10,
  localparam int IDW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
  localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [N_BTN-1:0] iBtn,
  input  logic             iEvt_ready,
  input  logic             iOvf_clr,
  output logic             oEvt_valid,
  output logic [IDW-1:0]   oEvt_id,
  output logic [1:0]       oEvt_type,
  output logic [N_BTN-1:0] oLevel,
  output logic             oOvf
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DB_P = 3'd1,
    ST_HELD = 3'd2,
    ST_LONG = 3'd3,
    ST_DB_R = 3'd4
  } st_t;

  // Pending-bit index equals the event type code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;
  localparam logic [1:0] T_REPEAT  = 2'b11;

  logic [PW-1:0]          presc_r;
  logic                   tick_s;
  logic [N_BTN-1:0]       sync1_r;
  logic [N_BTN-1:0]       sync2_r;
  logic [N_BTN-1:0][3:0]  raise_s;
  logic [N_BTN-1:0][3:0]  pend_r;
  logic [N_BTN-1:0][3:0]  clr_mask_s;
  logic                   ovf_set_s;
  logic                   load_s;
  logic                   found_s;
  logic [IDW-1:0]         win_id_s;
  logic [1:0]             win_type_s;
  logic [IDW-1:0]         ptr_r;
  logic                   evt_valid_r;
  logic [IDW-1:0]         evt_id_r;
  logic [1:0]             evt_type_r;
  logic                   ovf_r;

  assign tick_s = (presc_r == PW'(TICK_DIV - 1));

  // Shared tick prescaler
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      presc_r <= '0;
    end else if (tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Two-flop synchronisers for the asynchronous button inputs
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= iBtn;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    st_t              st_r;
    logic             ret_long_r;
    logic [CNT_W-1:0] tcnt_r;
    logic             lvl_r;
    logic             s_s;
    logic             db_hit_s;
    logic             long_hit_s;
    logic             rep_hit_s;

    assign s_s        = sync2_r[g];
    assign db_hit_s   = tick_s && (tcnt_r == CNT_W'(DB_TICKS - 1));
    assign long_hit_s = tick_s && (tcnt_r == CNT_W'(LONG_TICKS - 1));
    assign rep_hit_s  = tick_s && (tcnt_r == CNT_W'(REPEAT_TICKS - 1));

    // A level change always wins over a same-cycle tick, so raises require the level to hold
    assign raise_s[g] = {(st_r == ST_LONG) && s_s && rep_hit_s,
                         (st_r == ST_HELD) && s_s && long_hit_s,
                         (st_r == ST_DB_R) && !s_s && db_hit_s,
                         (st_r == ST_DB_P) && s_s && db_hit_s};
    assign oLevel[g] = lvl_r;

    // Per-button debounce and press classification FSM
    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        st_r       <= ST_IDLE;
        ret_long_r <= 1'b0;
        tcnt_r     <= '0;
        lvl_r      <= 1'b0;
      end else begin
        case (st_r)
          ST_IDLE: begin
            if (s_s) begin
              st_r   <= ST_DB_P;
              tcnt_r <= '0;
            end
          end
          ST_DB_P: begin
            if (!s_s) begin
              st_r   <= ST_IDLE;
              tcnt_r <= '0;
            end else if (db_hit_s) begin
              st_r   <= ST_HELD;
              tcnt_r <= '0;
              lvl_r  <= 1'b1;
            end else if (tick_s) begin
              tcnt_r <= tcnt_r + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!s_s) begin
              st_r       <= ST_DB_R;
              ret_long_r <= 1'b0;
              tcnt_r     <= '0;
            end else if (long_hit_s) begin
              st_r   <= ST_LONG;
              tcnt_r <= '0;
            end else if (tick_s) begin
              tcnt_r <= tcnt_r + CNT_W'(1);
            end
          end
          ST_LONG: begin
            if (!s_s) begin
              st_r       <= ST_DB_R;
              ret_long_r <= 1'b1;
              tcnt_r     <= '0;
            end else if (rep_hit_s) begin
              tcnt_r <= '0;
            end else if (tick_s) begin
              tcnt_r <= tcnt_r + CNT_W'(1);
            end
          end
          ST_DB_R: begin
            // A bounce back to pressed resumes the held state with its timing restarted
            if (s_s) begin
              st_r   <= ret_long_r ? ST_LONG : ST_HELD;
              tcnt_r <= '0;
            end else if (db_hit_s) begin
              st_r   <= ST_IDLE;
              tcnt_r <= '0;
              lvl_r  <= 1'b0;
            end else if (tick_s) begin
              tcnt_r <= tcnt_r + CNT_W'(1);
            end
          end
          default: begin
            st_r   <= ST_IDLE;
            tcnt_r <= '0;
          end
        endcase
      end
    end
  end

  assign load_s = !evt_valid_r || iEvt_ready;

  // Round-robin winner search starting after the last granted button
  always_comb begin
    logic [IDW-1:0] cand;
    cand       = '0;
    found_s    = 1'b0;
    win_id_s   = '0;
    win_type_s = T_PRESS;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = IDW'((int'(ptr_r) + k) % N_BTN);
      if (!found_s && (pend_r[cand] != 4'b0000)) begin
        found_s  = 1'b1;
        win_id_s = cand;
      end else begin
        found_s = found_s;
      end
    end
    if (pend_r[win_id_s][T_PRESS]) begin
      win_type_s = T_PRESS;
    end else if (pend_r[win_id_s][T_LONG]) begin
      win_type_s = T_LONG;
    end else if (pend_r[win_id_s][T_REPEAT]) begin
      win_type_s = T_REPEAT;
    end else begin
      win_type_s = T_RELEASE;
    end
  end

  // Pending bit consumed by the output slot this cycle
  always_comb begin
    clr_mask_s = '0;
    if (load_s && found_s) begin
      clr_mask_s[win_id_s][win_type_s] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
  end

  assign ovf_set_s = |(raise_s & pend_r & ~clr_mask_s);

  // Pending bits: a new raise wins over a same-cycle clear
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      pend_r <= '0;
    end else begin
      pend_r <= (pend_r & ~clr_mask_s) | raise_s;
    end
  end

  // Output event slot and arbitration pointer
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      evt_valid_r <= 1'b0;
      evt_id_r    <= '0;
      evt_type_r  <= 2'b00;
      ptr_r       <= IDW'(N_BTN - 1);
    end else if (load_s) begin
      if (found_s) begin
        evt_valid_r <= 1'b1;
        evt_id_r    <= win_id_s;
        evt_type_r  <= win_type_s;
        ptr_r       <= win_id_s;
      end else begin
        evt_valid_r <= 1'b0;
      end
    end
  end

  // Sticky overflow flag; setting dominates clearing
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (iOvf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign oEvt_valid = evt_valid_r;
  assign oEvt_id    = evt_id_r;
  assign oEvt_type  = evt_type_r;
  assign oOvf       = ovf_r;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: directed button sequences push expected
// events; a negedge monitor pops and compares each accepted event.
module tb_btn_event_ctrl;
  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_LONG    = 2'b10;
  localparam logic [1:0] T_REPEAT  = 2'b11;

  logic       iClk = 1'b0;
  logic       iRst_n;
  logic [3:0] iBtn;
  logic       iEvt_ready;
  logic       iOvf_clr;
  logic       oEvt_valid;
  logic [1:0] oEvt_id;
  logic [1:0] oEvt_type;
  logic [3:0] oLevel;
  logic       oOvf;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  logic [3:0] exp_q[$];
  int log_cyc[$];
  logic [3:0] mon_exp;

  btn_event_ctrl #(
    .N_BTN(4), .TICK_DIV(4), .DB_TICKS(3), .LONG_TICKS(10),
    .REPEAT_TICKS(5), .CNT_W(4)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iBtn(iBtn), .iEvt_ready(iEvt_ready),
    .iOvf_clr(iOvf_clr), .oEvt_valid(oEvt_valid), .oEvt_id(oEvt_id),
    .oEvt_type(oEvt_type), .oLevel(oLevel), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [1:0] typ);
    exp_q.push_back({id, typ});
  endtask

  // Monitor: one comparison per accepted event
  always @(negedge iClk) begin
    if (iRst_n && oEvt_valid && iEvt_ready) begin
      log_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_evt: got id %0d type %0d expected no event", oEvt_id, oEvt_type);
      end else begin
        mon_exp = exp_q.pop_front();
        check("evt_id_type", {28'd0, oEvt_id, oEvt_type}, {28'd0, mon_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    iRst_n = 1'b0; iBtn = 4'b0000; iEvt_ready = 1'b1; iOvf_clr = 1'b0;
    step(3);
    check("rst_valid", oEvt_valid, 0);
    check("rst_level", oLevel, 0);
    check("rst_ovf", oOvf, 0);
    check("rst_id_type", {oEvt_id, oEvt_type}, 0);
    iRst_n = 1'b1;
    step(2);

    // Short glitch of two ticks: filtered out
    iBtn[0] = 1'b1; step(8); iBtn[0] = 1'b0; step(24);
    check("t1_level", oLevel, 0);
    check("t1_no_evt", log_cyc.size(), 0);

    // Plain press/release on button 2
    push(2'd2, T_PRESS); push(2'd2, T_RELEASE);
    iBtn[2] = 1'b1; step(24);
    check("t2_level_hi", oLevel, 4'b0100);
    iBtn[2] = 1'b0; step(24);
    check("t2_level_lo", oLevel, 0);
    check("t2_evt_cnt", log_cyc.size(), 2);

    // Long hold on button 0: press, long, three repeats, release
    log_cyc.delete();
    push(2'd0, T_PRESS); push(2'd0, T_LONG);
    push(2'd0, T_REPEAT); push(2'd0, T_REPEAT); push(2'd0, T_REPEAT);
    push(2'd0, T_RELEASE);
    iBtn[0] = 1'b1; step(120); iBtn[0] = 1'b0; step(24);
    check("t3_evt_cnt", log_cyc.size(), 6);
    if (log_cyc.size() >= 4) begin
      check("t3_long_gap", log_cyc[1] - log_cyc[0], 40);
      check("t3_rep1_gap", log_cyc[2] - log_cyc[1], 20);
      check("t3_rep2_gap", log_cyc[3] - log_cyc[2], 20);
    end

    // Round robin: pointer on 1, simultaneous RELEASE id1 and PRESS id3
    push(2'd1, T_PRESS);
    iBtn[1] = 1'b1; step(24);
    log_cyc.delete();
    push(2'd3, T_PRESS); push(2'd1, T_RELEASE);
    iBtn = 4'b1000; step(24);
    check("t4_evt_cnt", log_cyc.size(), 2);
    if (log_cyc.size() >= 2) begin
      check("t4_b2b_gap", log_cyc[1] - log_cyc[0], 1);
    end
    push(2'd3, T_RELEASE);
    iBtn = 4'b0000; step(24);

    // Back-pressure: stalled PRESS, second REPEAT overflows
    check("t5_ovf_pre", oOvf, 0);
    iEvt_ready = 1'b0;
    push(2'd0, T_PRESS); push(2'd0, T_LONG); push(2'd0, T_REPEAT); push(2'd0, T_RELEASE);
    iBtn[0] = 1'b1; step(100);
    check("t5_hold_valid", oEvt_valid, 1);
    check("t5_hold_id_type", {oEvt_id, oEvt_type}, {2'd0, T_PRESS});
    iBtn[0] = 1'b0; step(24);
    check("t5_ovf_set", oOvf, 1);
    check("t5_stable_id_type", {oEvt_id, oEvt_type}, {2'd0, T_PRESS});
    iOvf_clr = 1'b1; step(1); iOvf_clr = 1'b0;
    check("t5_ovf_clr", oOvf, 0);
    iEvt_ready = 1'b1; step(10);
    check("t5_drained", exp_q.size(), 0);

    // Reset in the LONG state; button released during reset
    push(2'd0, T_PRESS); push(2'd0, T_LONG);
    iBtn[0] = 1'b1; step(60);
    check("t6_level_pre", oLevel, 4'b0001);
    check("t6_q_pre", exp_q.size(), 0);
    iRst_n = 1'b0; #1;
    check("t6_rst_valid", oEvt_valid, 0);
    check("t6_rst_level", oLevel, 0);
    check("t6_rst_ovf", oOvf, 0);
    step(1);
    iRst_n = 1'b1; iBtn = 4'b0000;
    step(40);
    check("t6_level_post", oLevel, 0);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge iClk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
Multi-button front-end controller that shares one timebase and one event output among N_BTN raw push-buttons. Per button it synchronises the input, debounces it on a shared millisecond-class tick, and classifies press/release/long-press/auto-repeat. Events are queued as pending bits and drained one at a time through a round-robin arbiter onto a valid/ready event stream. It sits between board buttons and the control FSMs that consume key events.

Parameters:
N_BTN, 4, number of buttons (1..16)
TICK_DIV, 100000, clocks per shared tick (>=2)
DB_TICKS, 20, stable ticks needed to accept a press or release (>=1)
LONG_TICKS, 1000, ticks in HELD before a LONG event (>=1)
REPEAT_TICKS, 200, ticks between REPEAT events in LONG state (>=1)
CNT_W, 10, per-button tick counter width; must hold max(DB,LONG,REPEAT)_TICKS-1

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iBtn  in  N_BTN  raw buttons, 1 = pressed, asynchronous
iEvt_ready  in  1  consumer accepts event
iOvf_clr  in  1  clears oOvf
oEvt_valid  out  1  event present
oEvt_id  out  max(1,clog2(N_BTN))  button index
oEvt_type  out  2  00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT
oLevel  out  N_BTN  debounced level per button
oOvf  out  1  sticky: an event was merged into an already-pending one

Behaviour:
- Reset (iRst_n=0, async): all outputs 0, prescaler 0, sync flops 0, all FSMs IDLE, pending bits 0, RR pointer = N_BTN-1. Release of reset mid-press: button must debounce from IDLE again; no RELEASE for pre-reset presses.
- Prescaler counts 0..TICK_DIV-1, wraps; tick = 1 for the single cycle when count == TICK_DIV-1.
- Input sync: 2 flops per bit; s[i] = second flop. FSM sees s only.
- Per-button FSM, counter tcnt cleared on every state entry, incremented only on tick. Level check has priority over tick in the same cycle.
  IDLE: s=1 -> DB_P.
  DB_P: s=0 -> IDLE, no event. tick && tcnt==DB_TICKS-1 -> HELD, raise PRESS, oLevel[i]<=1.
  HELD: s=0 -> DB_R(ret=HELD). tick && tcnt==LONG_TICKS-1 -> LONG, raise LONG.
  LONG: s=0 -> DB_R(ret=LONG). tick && tcnt==REPEAT_TICKS-1 -> raise REPEAT, tcnt<=0, stay.
  DB_R: s=1 -> ret state, tcnt<=0 (long/repeat timing restarts; no new PRESS). tick && tcnt==DB_TICKS-1 -> IDLE, raise RELEASE, oLevel[i]<=0.
- Pending: pend[i][type] set on the same edge as the raising transition. Raise while bit already 1 and not being loaded this cycle -> bit stays 1, oOvf<=1. Raise in the same cycle the bit is loaded to output -> bit ends 1 (set wins), no overflow.
- Output slot: loads when oEvt_valid=0 or (oEvt_valid && iEvt_ready). Search buttons starting at pointer+1 modulo N_BTN; first button with any pend bit wins; within it priority PRESS > LONG > REPEAT > RELEASE. Loaded bit cleared, pointer <= winner. Nothing pending -> oEvt_valid<=0.
- Latency: pend bit visible cycle T -> oEvt_valid/id/type visible T+1 if slot free. Back-to-back events with iEvt_ready=1 stream at one per clock.
- oEvt_id/type held stable while oEvt_valid && !iEvt_ready.
- oOvf: set as above; iOvf_clr=1 clears it; set and clear in the same cycle -> stays 1.

Test Plan:
(params N_BTN=4, TICK_DIV=4, DB_TICKS=3, LONG_TICKS=10, REPEAT_TICKS=5)
- iBtn[0] high for 2 ticks then low -> no event, oLevel=0000, FSM back in IDLE.
- iBtn[2] high for 6 ticks then low, ready=1 -> exactly one PRESS id2 (~3 ticks after sync), oLevel[2]=1, then one RELEASE id2 3 ticks after the low sync; oLevel[2]=0.
- iBtn[0] held 30 ticks -> PRESS at 3 ticks, LONG 10 ticks later, REPEAT every 5 ticks (20 clocks apart), RELEASE after the low input is debounced.
- Press btn1 alone (PRESS id1 granted, pointer=1), then drop btn1 and raise btn3 so RELEASE id1 and PRESS id3 pend the same cycle -> id3 PRESS emitted first, id1 RELEASE on the next clock.
- Hold iEvt_ready=0 while btn0 produces two REPEATs -> oOvf=1, one REPEAT pending, oEvt_* stable. Pulse iOvf_clr -> oOvf=0. ready=1 drains remaining events in order.
- Drive iRst_n=0 mid-LONG for 1 clock -> all outputs 0 immediately. Release the button after reset -> no RELEASE event.
